seg7_scan_ctrl: RTL
===================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller that drives an N-digit common-anode 7-segment display from one shared seg7 decoder.
//  Sits between the stopwatch BCD counters and the board pins.
//  Snapshots the BCD word once per frame, so no digit tears.
//  Also handles per-slot ghost blanking, leading-zero suppression and invalid-code masking.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned, legal range 2..8
//  PRESCALE      50000  clk cycles per digit slot, >=2
//  BLANK_CYCLES  1000   cycles at the start of each slot with all anodes off, < PRESCALE
// PORTS
//  clk          in   1             system clock; the only clock
//  rst_n        in   1             asynchronous, active-low reset
//  en           in   1             scan enable
//  digits_bcd   in   4*NUM_DIGITS  BCD digits; digit i = [4i+3:4i], digit 0 = least significant
//  dp_mask      in   NUM_DIGITS    1 = decimal point lit on digit i
//  lz_suppress  in   1             1 = blank leading zeros
//  freeze       in   1             1 = hold the current snapshot (lap display)
//  an_n         out  NUM_DIGITS    anode selects, active-low, at most one low
//  seg_n        out  7             segments {g,f,e,d,c,b,a}, active-low
//  dp_n         out  1             decimal point, active-low
//  frame_tick   out  1             one-cycle pulse when a full scan completes
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - Internal state: pre_cnt=0, idx=0, snap=0.
//   - Outputs: an_n all 1, seg_n=7'h7F, dp_n=1, frame_tick=0.
//  Prescaler:
//   - pre_cnt counts 0..PRESCALE-1 while en=1.
//   - slot_end = en && pre_cnt==PRESCALE-1.
//   - On slot_end, pre_cnt wraps to 0 and idx advances 0,1,..,NUM_DIGITS-1, then wraps to 0.
//  Frame:
//   - frame_tick=1 on the cycle after slot_end with idx==NUM_DIGITS-1.
//  Snapshot:
//   - snap<=digits_bcd and dp snapshot<=dp_mask on the first en cycle after reset or after en=0 (load flag).
//   - Also on every frame wrap, unless freeze=1.
//   - freeze only blocks reloads; it never stalls the scan.
//  Output registers:
//   - an_n, seg_n and dp_n are registered.
//   - They reflect the pre_cnt/idx of the previous cycle (1-cycle latency).
//  Blanking:
//   - Applies when pre_cnt<BLANK_CYCLES or en=0.
//   - Forces an_n all 1, seg_n=7'h7F, dp_n=1.
//  Active slot (otherwise):
//   - an_n has a single 0 at bit idx.
//   - dp_n = ~dp snapshot[idx].
//  Segment code for nibble d = snap[idx]:
//   - d>9: SEG_DASH (7'b0111111). The decoder input is forced to 0 so it never receives codes >9.
//   - Suppressed (see below): SEG_BLANK.
//   - Otherwise: the decoder output for d.
//  Leading-zero suppression:
//   - Digit k (k>=1) is suppressed iff lz_suppress=1 and snap digits NUM_DIGITS-1..k are all 0.
//   - Digit 0 is never suppressed.
//   - dp is still shown on a suppressed digit.
//  en deasserted mid-slot:
//   - Next cycle is blanked; pre_cnt and idx clear to 0.
//   - Re-enable restarts at slot 0 with a fresh snapshot.
//  Simultaneous events:
//   - Frame wrap with freeze=1: no reload.
//   - Frame wrap with en falling: en wins; no frame_tick.
//  Widths:
//   - pre_cnt is $clog2(PRESCALE) bits; idx is $clog2(NUM_DIGITS) bits (min 1).
//   - Comparisons are unsigned and sized to the counter width.
// STRUCTURE
//  seg7_pkg constants:
//   - SEG_BLANK=7'h7F, SEG_DASH=7'h3F, NUM_DIGITS_MAX=8.
//   - Anode/segment polarity constants.
//  Sub-modules:
//   - Exactly one instance of the seg7 BCD decoder (digit[3:0] -> seg[6:0] active-low), combinational.
//   - Placed between the snapshot mux and the seg_n register.
//  Everything else stays in this module:
//   - Prescaler, scan index, snapshot, LZ logic, output registers.
//  Assertions:
//   - $onehot0(~an_n).
//   - Decoder input <=9.
//   - frame_tick is never high on two consecutive cycles.
// TESTING  (bench params NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1)
//  1. Reset:
//     - rst_n low mid-slot -> an_n=4'b1111, seg_n=7'h7F the same cycle.
//     - Release with en=1, digits=16'h1234 -> first lit slot an_n=1110, seg_n=7'b0011001 ('4').
//  2. Scan order:
//     - Free run -> an_n sequence 1110,1101,1011,0111 (each lit 3 of 4 cycles).
//     - frame_tick period is exactly 16 cycles.
//  3. Snapshot/freeze:
//     - digits 16'h1234->16'h5678 mid-frame -> display unchanged until the wrap, then 5678.
//     - freeze=1 across 3 frames -> still 1234.
//  4. Leading zeros:
//     - lz=1, 16'h0040 -> digits 3,2 seg_n=7F; digit 1=7'b0011001; digit 0=7'b1000000.
//     - 16'h0000 -> only digit 0 lit.
//  5. Invalid code:
//     - 16'h12A4 -> digit 1 shows 7'b0111111.
//     - Decoder input assertion never fires.
//  6. Enable:
//     - en=0 mid-slot 2 -> next cycle all blank; frame_tick stays 0.
//     - en=1 -> restart at an_n=1110 with digits re-sampled.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : seg7_pkg
//  Description : Shared constants and types for the 7-segment scan
//                controller. Segment codes are active-low, in the bit
//                order {g,f,e,d,c,b,a}.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Largest digit count the scan controller supports
    localparam int NUM_DIGITS_MAX = 8;

    // Active-low segment patterns
    localparam logic [6:0] SEG_BLANK = 7'h7F;   // every segment dark
    localparam logic [6:0] SEG_DASH  = 7'h3F;   // only segment g lit

    // Pin polarities: common-anode board, everything active-low
    localparam logic AN_ON   = 1'b0;
    localparam logic AN_OFF  = 1'b1;
    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_scan_ctrl_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl_decoder
//  Description : Combinational BCD to 7-segment decoder with active-low
//                outputs {g,f,e,d,c,b,a}. The caller guarantees that the
//                input is never above 9.
//  Ports       : digit [3:0] in  - BCD digit 0..9
//                seg   [6:0] out - active-low segment pattern
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
    end

endmodule : seg7_scan_ctrl_decoder
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Time-multiplexed scan controller for an N-digit common-anode
//                7-segment display sharing one BCD decoder. The BCD word is
//                snapshotted once per frame so digits never tear. Each slot
//                starts with a short all-dark window to hide ghosting;
//                leading-zero suppression and invalid-code masking are built
//                in.
//  Ports       : clk         in  - system clock
//                rst_n       in  - asynchronous active-low reset
//                en          in  - scan enable
//                digits_bcd  in  - packed BCD digits, digit 0 in [3:0]
//                dp_mask     in  - 1 = decimal point lit on digit i
//                lz_suppress in  - 1 = blank leading zeros
//                freeze      in  - 1 = hold current snapshot at frame wrap
//                an_n        out - anode selects, active-low
//                seg_n       out - segments {g,f,e,d,c,b,a}, active-low
//                dp_n        out - decimal point, active-low
//                frame_tick  out - one-cycle pulse after each full scan
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_suppress,
    input  logic                    freeze,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_tick
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] c_pre_last  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] c_blank_end = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] c_idx_last  = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           r_pre_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_snap;
    logic [NUM_DIGITS-1:0]   r_dp_snap;
    logic                    r_load;
    logic [NUM_DIGITS-1:0]   r_an_n;
    logic [6:0]              r_seg_n;
    logic                    r_dp_n;
    logic                    r_frame_tick;

    logic                    w_slot_end;
    logic                    w_frame_wrap;
    logic                    w_blank;
    logic [4*NUM_DIGITS-1:0] w_snap;
    logic [NUM_DIGITS-1:0]   w_dp_snap;
    bcd_t                    w_nib;
    logic                    w_dp_bit;
    logic                    w_zero_above;
    logic                    w_supp;
    logic [NUM_DIGITS-1:0]   w_an_next;
    bcd_t                    w_dec_in;
    seg_t                    w_dec_seg;
    seg_t                    w_seg_next;

    assign w_slot_end   = en && (r_pre_cnt == c_pre_last);
    assign w_frame_wrap = w_slot_end && (r_idx == c_idx_last);
    assign w_blank      = !en || (r_pre_cnt < c_blank_end);

    // While the load flag is pending the register has not captured yet, so
    // the live inputs stand in for it; the first lit cycle then never shows
    // stale data even with no blanking window.
    assign w_snap    = r_load ? digits_bcd : r_snap;
    assign w_dp_snap = r_load ? dp_mask    : r_dp_snap;

    // Select the current digit and work out suppression. Walking from the
    // most significant digit down, w_zero_above stays high only while every
    // digit from the top through the current one is zero.
    always_comb begin
        w_nib        = 4'd0;
        w_dp_bit     = 1'b0;
        w_supp       = 1'b0;
        w_zero_above = 1'b1;
        w_an_next    = {NUM_DIGITS{AN_OFF}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (w_snap[4*i +: 4] == 4'd0);
            if (IW'(i) == r_idx) begin
                w_nib        = w_snap[4*i +: 4];
                w_dp_bit     = w_dp_snap[i];
                w_an_next[i] = AN_ON;
                w_supp       = lz_suppress && (i != 0) && w_zero_above;
            end
        end
    end

    // Non-BCD nibbles are steered to 0 so the decoder only ever sees 0..9;
    // the dash is substituted afterwards.
    assign w_dec_in = (w_nib > 4'd9) ? 4'd0 : w_nib;

    seg7_scan_ctrl_decoder u_decoder (
        .digit (w_dec_in),
        .seg   (w_dec_seg)
    );

    always_comb begin
        w_seg_next = w_dec_seg;
        if (w_nib > 4'd9) begin
            w_seg_next = SEG_DASH;
        end else if (w_supp) begin
            w_seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt    <= '0;
            r_idx        <= '0;
            r_snap       <= '0;
            r_dp_snap    <= '0;
            r_load       <= 1'b1;
            r_an_n       <= {NUM_DIGITS{AN_OFF}};
            r_seg_n      <= SEG_BLANK;
            r_dp_n       <= SEG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            // Scan position; disabling parks the scan at slot 0 and arms a
            // fresh snapshot for the next enable.
            if (!en) begin
                r_pre_cnt <= '0;
                r_idx     <= '0;
                r_load    <= 1'b1;
            end else begin
                if (w_slot_end) begin
                    r_pre_cnt <= '0;
                    r_idx     <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
                end else begin
                    r_pre_cnt <= r_pre_cnt + 1'b1;
                end
                if (r_load || (w_frame_wrap && !freeze)) begin
                    r_snap    <= digits_bcd;
                    r_dp_snap <= dp_mask;
                end
                r_load <= 1'b0;
            end

            r_frame_tick <= w_frame_wrap;

            if (w_blank) begin
                r_an_n  <= {NUM_DIGITS{AN_OFF}};
                r_seg_n <= SEG_BLANK;
                r_dp_n  <= SEG_OFF;
            end else begin
                r_an_n  <= w_an_next;
                r_seg_n <= w_seg_next;
                r_dp_n  <= w_dp_bit ? SEG_ON : SEG_OFF;
            end
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign frame_tick = r_frame_tick;

`ifndef SYNTHESIS
    a_param_range: assert property (@(posedge clk)
        (NUM_DIGITS >= 2) && (NUM_DIGITS <= NUM_DIGITS_MAX) &&
        (PRESCALE >= 2) && (BLANK_CYCLES < PRESCALE));
    a_an_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(~an_n));
    a_dec_range: assert property (@(posedge clk) disable iff (!rst_n)
        w_dec_in <= 4'd9);
    a_tick_single: assert property (@(posedge clk) disable iff (!rst_n)
        frame_tick |=> !frame_tick);
`endif

endmodule : seg7_scan_ctrl
`default_nettype wire
